imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction memory that the fetch stage reads: accepts a byte stream over a valid/ready handshake and packs it into 32-bit instruction words.
- Writes each word into sequential instruction-memory addresses starting at 0.
- Holds the CPU out of execution (cpu_run low) until the full program is loaded, then releases it.
- Sits between the external program source (testbench, UART front end) and the instruction memory write port, alongside the CPU top.

Parameters:
- DEPTH, 256, instruction memory capacity in 32-bit words.
- ADDR_W, 8, word-address width; must satisfy 2**ADDR_W >= DEPTH.

Ports:
- clk  input  1  system clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  single-cycle pulse; begins (re)load from address 0
- byte_valid  input  1  byte_data/byte_last are valid
- byte_data  input  8  program byte
- byte_last  input  1  qualifies the final byte of the program
- byte_ready  output  1  loader can accept a byte this cycle
- wr_en  output  1  instruction memory write strobe
- wr_addr  output  ADDR_W  word address for the write
- wr_data  output  32  packed instruction word
- words_written  output  ADDR_W+1  count of words committed in the current load
- load_done  output  1  program fully loaded
- cpu_run  output  1  CPU release; high only in DONE
- overflow  output  1  sticky error: program exceeded DEPTH words

Behaviour:
- Reset (asynchronous, any state, including mid-load): state=IDLE; byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, words_written=0, load_done=0, cpu_run=0, overflow=0. The byte lane counter and assembly register are cleared.
- A byte is accepted only when byte_valid && byte_ready in the same cycle. byte_data and byte_last are ignored otherwise.
- Packing is little-endian: the 1st accepted byte goes to bits [7:0] and the 4th to bits [31:24].

States:
- IDLE:
  - byte_ready=0.
  - start -> COLLECT; the word index, lane counter and words_written are cleared.
- COLLECT:
  - byte_ready=1, except when word index == DEPTH.
  - Each accepted byte is placed in its lane and the lane counter increments.
  - If the accepted byte is lane 3, or byte_last=1, the next state is WRITE.
  - On byte_last in lanes 0–2, unfilled upper lanes are zero-filled and a last flag is latched.
  - If word index == DEPTH and byte_valid=1, the next state is ERROR; the byte is not accepted.
- WRITE (exactly one cycle):
  - byte_ready=0; wr_en=1; wr_addr=word index; wr_data=assembled word.
  - Next cycle: word index +1, words_written +1, lane counter = 0.
  - If the last flag is set, go to DONE; otherwise go to COLLECT.
- DONE:
  - load_done=1, cpu_run=1, byte_ready=0.
  - start -> COLLECT (reload). cpu_run and load_done drop the cycle after start.
  - byte_valid is ignored.
- ERROR:
  - overflow=1, byte_ready=0, cpu_run=0. The state is sticky; only rst exits it.
  - start is ignored.

Timing and boundary rules:
- Latency: the write strobe occurs 1 cycle after the 4th (or last) byte is accepted. Throughput is 4 bytes per 5 cycles at most.
- start while in COLLECT or WRITE is ignored.
- A program of exactly DEPTH words reaches DONE with no overflow. One extra byte causes ERROR.
- wr_en is never asserted in IDLE, DONE or ERROR.
- wr_addr and wr_data hold their last values when wr_en=0.

Decomposition:
- Shared package cpu_pkg holds:
  - typedef loader_state_t, an enum {IDLE, COLLECT, WRITE, DONE, ERROR};
  - localparam INSTR_W = 32;
  - localparam BYTES_PER_INSTR = 4.
- One sub-module, byte_packer: lane counter, little-endian assembly register, zero-fill on last. Its outputs are word_ready and word.
- The FSM, address counter and error logic stay in imem_loader.

Test Plan:
- Basic load (DEPTH=4): start, then bytes 0x11,0x22,0x33,0x44 (byte_last on 0x44). Expect one wr_en at addr 0 with data 0x44332211, then load_done=1, cpu_run=1, words_written=1.
- Partial word: after start, bytes 0xAA,0xBB with byte_last on 0xBB. Expect wr_data=0x0000BBAA at addr 0, then DONE.
- Backpressure and gaps: 8 bytes with byte_valid toggling randomly. Expect exactly 2 writes, to addrs 0 and 1, with correct packing. byte_ready must be 0 during each WRITE cycle.
- Overflow (DEPTH=4): 16 bytes with no byte_last, then a 17th byte. Expect 4 writes (addrs 0–3) and overflow=1. The 17th byte is not accepted, cpu_run stays 0, and a later start is ignored.
- Reload: from DONE, pulse start and send 4 bytes 0x01..0x04 with last. cpu_run drops the next cycle. Expect a write at addr 0 with data 0x04030201, words_written back to 1, then DONE.
- Reset mid-operation: assert rst after 2 bytes are accepted. All outputs go to their reset values immediately, with no wr_en. A fresh start and 4 bytes then produce a write at addr 0 with no stale lanes.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction-memory loader.
package cpu_pkg;
  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, DONE, ERROR} loader_state_t;
  localparam int INSTR_W         = 32;
  localparam int BYTES_PER_INSTR = 4;
endpackage

// File: rtl/byte_packer.sv
// Packs accepted bytes little-endian into an instruction word; word/word_ready are combinational
// on the completing accept (4th byte or byte_last). It never stalls: the caller gates accept.
module byte_packer
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               accept,
  input  logic [7:0]         byte_data,
  input  logic               byte_last,
  output logic               word_ready,
  output logic [INSTR_W-1:0] word
);
  localparam int LANE_W = $clog2(BYTES_PER_INSTR);

  logic [LANE_W-1:0]  lane_q, lane_d;
  logic [INSTR_W-1:0] asm_q, asm_d;

  always_comb begin
    // Lanes above the current byte are zeroed, so a short final word needs no extra pass.
    word = asm_q;
    for (int i = 0; i < BYTES_PER_INSTR; i++) begin
      if (i == int'(lane_q)) begin
        word[8*i +: 8] = byte_data;
      end else if (i > int'(lane_q)) begin
        word[8*i +: 8] = 8'h00;
      end
    end
    word_ready = accept && (byte_last || (lane_q == LANE_W'(BYTES_PER_INSTR - 1)));

    lane_d = lane_q;
    asm_d  = asm_q;
    if (clear) begin
      lane_d = '0;
      asm_d  = '0;
    end else if (accept) begin
      asm_d  = word;
      lane_d = word_ready ? '0 : lane_q + LANE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q <= '0;
      asm_q  <= '0;
    end else begin
      lane_q <= lane_d;
      asm_q  <= asm_d;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Byte stream -> sequential 32-bit imem writes; wr_en fires 1 cycle after the 4th/last byte.
// byte_ready is low outside COLLECT, during WRITE, and once DEPTH words are stored; cpu_run only in DONE.
module imem_loader
  import cpu_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  input  logic               byte_last,
  output logic               byte_ready,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [INSTR_W-1:0] wr_data,
  output logic [ADDR_W:0]    words_written,
  output logic               load_done,
  output logic               cpu_run,
  output logic               overflow
);
  localparam int               CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CAP   = CNT_W'(DEPTH);

  loader_state_t      state_q, state_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic               last_q, last_d;
  logic               byte_ready_q, byte_ready_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [INSTR_W-1:0] wr_data_q, wr_data_d;
  logic               done_q, done_d;
  logic               overflow_q, overflow_d;

  logic               accept;
  logic               packer_clear;
  logic               word_ready;
  logic [INSTR_W-1:0] word;

  assign accept = byte_valid && byte_ready_q;

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (packer_clear),
    .accept     (accept),
    .byte_data  (byte_data),
    .byte_last  (byte_last),
    .word_ready (word_ready),
    .word       (word)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    last_d       = last_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    packer_clear = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = COLLECT;
          idx_d        = '0;
          last_d       = 1'b0;
          packer_clear = 1'b1;
        end
      end
      COLLECT: begin
        if (idx_q == CAP) begin
          if (byte_valid) state_d = ERROR;
        end else if (word_ready) begin
          state_d   = WRITE;
          last_d    = byte_last;
          wr_addr_d = idx_q[ADDR_W-1:0];
          wr_data_d = word;
        end
      end
      WRITE: begin
        idx_d   = idx_q + CNT_W'(1);
        state_d = last_q ? DONE : COLLECT;
      end
      ERROR: state_d = ERROR;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    byte_ready_d = (state_d == COLLECT) && (idx_d != CAP);
    wr_en_d      = (state_d == WRITE);
    done_d       = (state_d == DONE);
    overflow_d   = (state_d == ERROR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      last_q       <= 1'b0;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      last_q       <= last_d;
      byte_ready_q <= byte_ready_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign byte_ready    = byte_ready_q;
  assign wr_en         = wr_en_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign words_written = idx_q;
  assign load_done     = done_q;
  assign cpu_run       = done_q;
  assign overflow      = overflow_q;
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader at DEPTH=4: table of directed programs, hand-written corner sequences,
// and random programs checked against a byte-list packing model.
module tb_imem_loader;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              byte_last = 1'b0;
  logic              byte_ready, wr_en, load_done, cpu_run, overflow;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [ADDR_W:0]   words_written;

  int checks = 0;
  int errors = 0;

  int          got_addr[$];
  logic [31:0] got_data[$];
  logic [31:0] exp_q[$];
  int          ready_viol = 0, hold_viol = 0, state_viol = 0;
  logic [ADDR_W-1:0] prev_addr;
  logic [31:0]       prev_data;

  typedef struct {
    int             n;
    logic [0:7][7:0] b;
    int             nw;
    logic [31:0]    w0;
    logic [31:0]    w1;
  } vec_t;
  vec_t tbl[5];

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_last(byte_last), .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .words_written(words_written), .load_done(load_done),
    .cpu_run(cpu_run), .overflow(overflow)
  );

  // Write monitor: captures every strobe and watches the invariants around it.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        got_addr.push_back(int'(wr_addr));
        got_data.push_back(wr_data);
        if (byte_ready) ready_viol++;
        if (load_done || cpu_run || overflow) state_viol++;
      end else if (wr_addr !== prev_addr || wr_data !== prev_data) begin
        hold_viol++;
      end
    end
    prev_addr = wr_addr;
    prev_data = wr_data;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic clear_capture();
    got_addr.delete();
    got_data.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l, input bit gaps);
    bit acc;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
        byte_last  = 1'b1;
        step();
      end
    end
    byte_valid = 1'b1;
    byte_data  = b;
    byte_last  = l;
    acc = 1'b0;
    for (int t = 0; t < 16 && !acc; t++) begin
      @(negedge clk);
      acc = byte_ready;
      step();
    end
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    chk("byte_accepted", acc, 1'b1);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 12 && !ok; t++) begin
      @(negedge clk);
      ok = load_done;
      if (!ok) step();
    end
  endtask

  // Reference: the i-th byte of a load sits in word i/4 at bit 8*(i%4).
  task automatic build_expected(input logic [7:0] bq[$]);
    exp_q.delete();
    for (int i = 0; i < bq.size(); i++) begin
      if (i % 4 == 0) exp_q.push_back(32'h0);
      exp_q[i/4] = exp_q[i/4] | (32'(bq[i]) << (8 * (i % 4)));
    end
  endtask

  task automatic check_writes(input string name);
    chk({name, "_nwrites"}, 64'(got_data.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
      chk({name, "_addr"}, 64'(got_addr[i]), 64'(i));
      chk({name, "_data"}, got_data[i], exp_q[i]);
    end
  endtask

  task automatic run_program(input string name, input logic [7:0] bq[$], input bit gaps);
    bit ok;
    clear_capture();
    pulse_start();
    for (int i = 0; i < bq.size(); i++) send_byte(bq[i], i == bq.size() - 1, gaps);
    wait_done(ok);
    chk({name, "_load_done"}, ok, 1'b1);
    chk({name, "_cpu_run"}, cpu_run, 1'b1);
    chk({name, "_words_written"}, 64'(words_written), 64'(exp_q.size()));
    chk({name, "_overflow"}, overflow, 1'b0);
    check_writes(name);
    step();
  endtask

  initial begin
    logic [7:0] bq[$];
    bit ok, saw_ready;

    tbl[0] = '{4, 64'h11223344_00000000, 1, 32'h44332211, 32'h0};
    tbl[1] = '{2, 64'hAABB0000_00000000, 1, 32'h0000BBAA, 32'h0};
    tbl[2] = '{5, 64'h01020304_05000000, 2, 32'h04030201, 32'h00000005};
    tbl[3] = '{3, 64'hDEADBE00_00000000, 1, 32'h00BEADDE, 32'h0};
    tbl[4] = '{8, 64'hF0E1D2C3_B4A59687, 2, 32'hC3D2E1F0, 32'h8796A5B4};

    // Reset values, then bytes offered without start must be refused.
    repeat (2) step();
    @(negedge clk);
    chk("reset_outputs", {byte_ready, wr_en, wr_addr, wr_data, words_written, load_done, cpu_run, overflow}, 64'h0);
    step();
    rst = 1'b0;
    clear_capture();
    byte_valid = 1'b1;
    byte_data  = 8'h5A;
    repeat (3) step();
    byte_valid = 1'b0;
    @(negedge clk);
    chk("idle_byte_ready", byte_ready, 1'b0);
    chk("idle_no_writes", 64'(got_data.size()), 64'h0);
    step();

    // Directed table: first from IDLE, the rest reload from DONE.
    for (int k = 0; k < 5; k++) begin
      bq.delete();
      for (int i = 0; i < tbl[k].n; i++) bq.push_back(tbl[k].b[i]);
      exp_q.delete();
      exp_q.push_back(tbl[k].w0);
      if (tbl[k].nw > 1) exp_q.push_back(tbl[k].w1);
      run_program($sformatf("tbl%0d", k), bq, k >= 3);
    end

    // Reload from DONE: cpu_run holds through the start cycle and drops right after it.
    clear_capture();
    start = 1'b1;
    @(negedge clk);
    chk("reload_cpu_run_during_start", cpu_run, 1'b1);
    step();
    start = 1'b0;
    @(negedge clk);
    chk("reload_cpu_run_dropped", cpu_run, 1'b0);
    chk("reload_load_done_dropped", load_done, 1'b0);
    chk("reload_byte_ready", byte_ready, 1'b1);
    step();
    for (int i = 1; i <= 4; i++) send_byte(8'(i), i == 4, 1'b0);
    wait_done(ok);
    chk("reload_done", ok, 1'b1);
    chk("reload_words_written", 64'(words_written), 64'd1);
    exp_q.delete();
    exp_q.push_back(32'h04030201);
    check_writes("reload");
    step();

    // start inside COLLECT and inside WRITE must not disturb the load.
    clear_capture();
    pulse_start();
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    pulse_start();
    send_byte(8'h03, 1'b0, 1'b0);
    send_byte(8'h04, 1'b0, 1'b0);
    pulse_start();
    send_byte(8'h05, 1'b1, 1'b0);
    wait_done(ok);
    chk("midstart_done", ok, 1'b1);
    chk("midstart_words_written", 64'(words_written), 64'd2);
    exp_q.delete();
    exp_q.push_back(32'h04030201);
    exp_q.push_back(32'h00000005);
    check_writes("midstart");
    step();

    // Random programs, the first exactly filling the memory.
    for (int k = 0; k < 6; k++) begin
      int n;
      n = (k == 0) ? 4 * DEPTH : int'($urandom_range(1, 4 * DEPTH));
      bq.delete();
      for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
      build_expected(bq);
      run_program($sformatf("rand%0d", k), bq, 1'b1);
    end

    // Overflow: a full memory with no byte_last, then one byte too many.
    bq.delete();
    for (int i = 0; i < 4 * DEPTH; i++) bq.push_back(8'($urandom));
    build_expected(bq);
    clear_capture();
    pulse_start();
    for (int i = 0; i < bq.size(); i++) send_byte(bq[i], 1'b0, 1'b1);
    byte_valid = 1'b1;
    byte_data  = 8'hEE;
    byte_last  = 1'b1;
    saw_ready  = 1'b0;
    for (int t = 0; t < 10 && !overflow; t++) begin
      @(negedge clk);
      if (byte_ready) saw_ready = 1'b1;
      step();
    end
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    @(negedge clk);
    chk("ovf_overflow", overflow, 1'b1);
    chk("ovf_extra_refused", saw_ready, 1'b0);
    chk("ovf_cpu_run", cpu_run, 1'b0);
    chk("ovf_load_done", load_done, 1'b0);
    chk("ovf_words_written", 64'(words_written), 64'(DEPTH));
    check_writes("ovf");
    step();
    pulse_start();
    repeat (3) step();
    @(negedge clk);
    chk("ovf_sticky", overflow, 1'b1);
    chk("ovf_sticky_ready", byte_ready, 1'b0);
    chk("ovf_sticky_cpu_run", cpu_run, 1'b0);
    chk("ovf_sticky_nwrites", 64'(got_data.size()), 64'(DEPTH));
    step();

    // Reset leaves ERROR; then reset again in the middle of a word.
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_clears_overflow", overflow, 1'b0);
    step();
    clear_capture();
    pulse_start();
    send_byte(8'hA1, 1'b0, 1'b0);
    send_byte(8'hA2, 1'b0, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_outputs", {byte_ready, wr_en, wr_addr, wr_data, words_written, load_done, cpu_run, overflow}, 64'h0);
    step();
    step();
    rst = 1'b0;
    chk("midrst_no_write", 64'(got_data.size()), 64'h0);
    bq.delete();
    for (int i = 0; i < 4; i++) bq.push_back(8'hB1 + 8'(i));
    exp_q.delete();
    exp_q.push_back(32'hB4B3B2B1);
    run_program("postrst", bq, 1'b0);

    chk("no_ready_during_write", 64'(ready_viol), 64'h0);
    chk("wr_fields_hold", 64'(hold_viol), 64'h0);
    chk("no_write_outside_write_state", 64'(state_viol), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
